// File: rtl/registro_universal_n.sv
// Parametrised universal shift register: shift, rotate, load, hold and counted bursts.
// Optional revolution counter (VUELTAS) enabled by defining CUENTA_VUELTAS_EN.
module registro_universal_n #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CNT_W-1:0] PASOS,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
`ifdef CUENTA_VUELTAS_EN
    ,
    output logic [7:0]       VUELTAS
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         lat_modo;
    logic               lat_dir;

    logic               run;
    logic [1:0]         eff_modo;
    logic               eff_dir;
    logic               starting;
    logic               step_en;
    logic [WIDTH-1:0]   nq;

    // Pick live or latched command and compute the next register value
    always_comb begin
        run      = (state == RUN);
        eff_modo = run ? lat_modo : MODO;
        eff_dir  = run ? lat_dir : DIR;
        starting = !run && START && !MODO[1];
        step_en  = ENB && !starting;
        nq       = Q;
        unique case (eff_modo)
            2'b00: nq = eff_dir ? {S_IN, Q[WIDTH-1:1]}
                                : {Q[WIDTH-2:0], S_IN};
            2'b01: nq = eff_dir ? {Q[0], Q[WIDTH-1:1]}
                                : {Q[WIDTH-2:0], Q[WIDTH-1]};
            2'b10: nq = D;
            2'b11: nq = Q;
        endcase
    end

    assign S_OUT = eff_dir ? Q[0] : Q[WIDTH-1];
    assign BUSY  = run;

    // Register contents, burst sequencing and the one-cycle DONE pulse
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state    <= IDLE;
            Q        <= '0;
            cnt      <= '0;
            lat_modo <= 2'b00;
            lat_dir  <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (ENB) begin
                if (starting) begin
                    lat_modo <= MODO;
                    lat_dir  <= DIR;
                    cnt      <= PASOS;
                    if (PASOS != '0) begin
                        state <= RUN;
                    end else begin
                        DONE <= 1'b1;
                    end
                end else begin
                    Q <= nq;
                    if (run) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                            DONE  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef CUENTA_VUELTAS_EN
    localparam int PH_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(WIDTH - 1);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] ph_next;

    // Phase moves with rotate direction and wraps modulo WIDTH
    always_comb begin
        if (eff_dir) begin
            ph_next = (phase == '0) ? PH_MAX : phase - 1'b1;
        end else begin
            ph_next = (phase == PH_MAX) ? '0 : phase + 1'b1;
        end
    end

    // Count full revolutions; shifts and loads lose the alignment
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            phase   <= '0;
            VUELTAS <= 8'd0;
        end else if (step_en) begin
            unique case (eff_modo)
                2'b01: begin
                    phase <= ph_next;
                    if (ph_next == '0) begin
                        VUELTAS <= VUELTAS + 8'd1;
                    end
                end
                2'b11: phase <= phase;
                default: phase <= '0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_registro_universal_n.sv
// Directed testbench for registro_universal_n (WIDTH=4, CNT_W=4).
// Revolution counter checks run only when CUENTA_VUELTAS_EN is defined.
module tb_registro_universal_n;

    logic       CLK = 1'b0;
    logic       RESET_L;
    logic       ENB;
    logic [1:0] MODO;
    logic       DIR;
    logic       S_IN;
    logic [3:0] D;
    logic       START;
    logic [3:0] PASOS;
    logic [3:0] Q;
    logic       S_OUT;
    logic       BUSY;
    logic       DONE;
`ifdef CUENTA_VUELTAS_EN
    logic [7:0] VUELTAS;
`endif

    int checks = 0;
    int failures = 0;

    registro_universal_n #(.WIDTH(4), .CNT_W(4)) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .ENB     (ENB),
        .MODO    (MODO),
        .DIR     (DIR),
        .S_IN    (S_IN),
        .D       (D),
        .START   (START),
        .PASOS   (PASOS),
        .Q       (Q),
        .S_OUT   (S_OUT),
        .BUSY    (BUSY),
        .DONE    (DONE)
`ifdef CUENTA_VUELTAS_EN
        ,
        .VUELTAS (VUELTAS)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [3:0] q,
                          input logic busy, input logic done);
        chk({tag, ".q"}, 32'(Q), 32'(q));
        chk({tag, ".busy"}, 32'(BUSY), 32'(busy));
        chk({tag, ".done"}, 32'(DONE), 32'(done));
    endtask

    initial begin
        RESET_L = 1'b1;
        ENB = 1'b0;
        MODO = 2'b11;
        DIR = 1'b0;
        S_IN = 1'b0;
        D = 4'h0;
        START = 1'b0;
        PASOS = 4'd0;
        #2 RESET_L = 1'b0;
        #1;
        chk_st("reset", 4'b0000, 1'b0, 1'b0);
`ifdef CUENTA_VUELTAS_EN
        chk("reset.vueltas", 32'(VUELTAS), 32'd0);
`endif
        #20 RESET_L = 1'b1;
        tick();

        // load and rotate
        ENB = 1'b1; MODO = 2'b10; D = 4'b1001;
        tick(); chk("load", 32'(Q), 32'b1001);
        MODO = 2'b01; DIR = 1'b0;
        tick(); chk("rotl", 32'(Q), 32'b0011);
        DIR = 1'b1;
        tick(); chk("rotr", 32'(Q), 32'b1001);

        // shift
        MODO = 2'b00; DIR = 1'b0; S_IN = 1'b1; #1;
        chk("sout.left", 32'(S_OUT), 32'd1);
        tick(); chk("shl", 32'(Q), 32'b0011);
        DIR = 1'b1; S_IN = 1'b0; #1;
        chk("sout.right", 32'(S_OUT), 32'd1);
        tick(); chk("shr", 32'(Q), 32'b0001);

        // burst rotate left 3
        MODO = 2'b01; DIR = 1'b0; PASOS = 4'd3; START = 1'b1;
        tick(); chk_st("b.start", 4'b0001, 1'b1, 1'b0);
        START = 1'b0; MODO = 2'b10; D = 4'b1111; DIR = 1'b1; #1;
        chk("b.sout_latched", 32'(S_OUT), 32'd0);
        tick(); chk_st("b.s1", 4'b0010, 1'b1, 1'b0);
        MODO = 2'b11;
        tick(); chk_st("b.s2", 4'b0100, 1'b1, 1'b0);
        tick(); chk_st("b.s3", 4'b1000, 1'b0, 1'b1);
        tick(); chk_st("b.after", 4'b1000, 1'b0, 1'b0);

        // burst shift right 4 with stall and dropped START
        MODO = 2'b00; DIR = 1'b1; S_IN = 1'b1; PASOS = 4'd4; START = 1'b1;
        tick(); chk_st("st.start", 4'b1000, 1'b1, 1'b0);
        START = 1'b0;
        tick(); chk_st("st.s1", 4'b1100, 1'b1, 1'b0);
        ENB = 1'b0; S_IN = 1'b0;
        tick(); chk_st("st.stall1", 4'b1100, 1'b1, 1'b0);
        tick(); chk_st("st.stall2", 4'b1100, 1'b1, 1'b0);
        ENB = 1'b1; S_IN = 1'b1; START = 1'b1; MODO = 2'b01; PASOS = 4'd1;
        tick(); chk_st("st.s2", 4'b1110, 1'b1, 1'b0);
        START = 1'b0; MODO = 2'b11; S_IN = 1'b0;
        tick(); chk_st("st.s3", 4'b0111, 1'b1, 1'b0);
        tick(); chk_st("st.s4", 4'b0011, 1'b0, 1'b1);
        ENB = 1'b0;
        tick(); chk_st("st.after", 4'b0011, 1'b0, 1'b0);

        // zero-length burst
        ENB = 1'b1; MODO = 2'b01; DIR = 1'b0; PASOS = 4'd0; START = 1'b1;
        tick(); chk_st("z.start", 4'b0011, 1'b0, 1'b1);
        START = 1'b0; MODO = 2'b11;
        tick(); chk_st("z.after", 4'b0011, 1'b0, 1'b0);

        // reset in the middle of a 5-step burst
        MODO = 2'b01; DIR = 1'b0; PASOS = 4'd5; START = 1'b1;
        tick(); chk_st("r.start", 4'b0011, 1'b1, 1'b0);
        START = 1'b0; MODO = 2'b11;
        tick(); chk_st("r.s1", 4'b0110, 1'b1, 1'b0);
        #2 RESET_L = 1'b0;
        #1 chk_st("r.async", 4'b0000, 1'b0, 1'b0);
        tick(); tick();
        #2 RESET_L = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); chk_st("r.quiet", 4'b0000, 1'b0, 1'b0);
        end

`ifdef CUENTA_VUELTAS_EN
        MODO = 2'b10; D = 4'b0001;
        tick();
        MODO = 2'b01; DIR = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("v.partial", 32'(VUELTAS), 32'd0);
        tick();
        chk("v.q", 32'(Q), 32'b0001);
        chk("v.one", 32'(VUELTAS), 32'd1);
        tick(); tick();
        MODO = 2'b10; D = 4'b0001;
        tick();
        chk("v.load", 32'(VUELTAS), 32'd1);
        MODO = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        chk("v.cleared", 32'(VUELTAS), 32'd1);
        tick();
        chk("v.two", 32'(VUELTAS), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
